// File: rtl/channel_rd_paged.sv
// channel_rd_paged
// ----------------
// SDRAM read channel feeding a paged on-chip buffer. An address generator
// walks a frame of tiles (nx steps of x_shift across, {row, bank} down) and
// issues one burst request per tile. Returned SDRAM data is written into the
// current write page; each finished burst commits one page. The consumer reads
// the oldest full page as 16-bit words and releases it with next_page.
//
// Every flop, including both RAM ports, is clocked on the falling edge of clk.
//
// Optional feature: define CHANNEL_RD_PAGED_COLUMN_ORDER_EN to enable column
// scan order (fill_order=1 makes {row, bank} the inner counter). Without the
// macro fill_order is ignored and only row order exists.
//
// Ports:
//   clk, rst_n         SDRAM clock (negedge active), async active-low reset
//   init               synchronous channel restart (RAM contents are kept)
//   enrq               request enable
//   fsa                frame start, SDRAM row address MSBs
//   x_max, x_shift,    tile geometry: burst length, nx step, nx count limit,
//   nx_max, y_max,     {row, bank} limit, scan order
//   fill_order
//   start              arbiter grant for the pending request
//   rq, rq_urgent      request / request while the buffer is empty
//   sa, len            SDRAM burst address and length
//   predrun, sddi      SDRAM data-valid strobe (one cycle early) and data
//   page_rdy, page_num oldest full page available to the consumer
//   ra, obdat          16-bit read address within that page, read data
//   next_page          consumer releases the current read page
//   frame_done, err    end-of-frame pulse, sticky write-without-page flag
module channel_rd_paged #(
    parameter int NPAGES  = 4,
    parameter int PAGE_AW = 8,
    parameter int Y_W     = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init,
    input  logic                      enrq,
    input  logic [11:0]               fsa,
    input  logic [4:0]                x_max,
    input  logic [7:0]                x_shift,
    input  logic [7:0]                nx_max,
    input  logic [Y_W-1:0]            y_max,
    input  logic                      fill_order,
    input  logic                      start,
    output logic                      rq,
    output logic                      rq_urgent,
    output logic [21:0]               sa,
    output logic [4:0]                len,
    input  logic                      predrun,
    input  logic [31:0]               sddi,
    output logic                      page_rdy,
    output logic [$clog2(NPAGES)-1:0] page_num,
    input  logic [PAGE_AW:0]          ra,
    output logic [15:0]               obdat,
    input  logic                      next_page,
    output logic                      frame_done,
    output logic                      err
);

    localparam int PW    = $clog2(NPAGES);
    localparam int FW    = PW + 1;
    localparam int DEPTH = NPAGES << PAGE_AW;

    logic              runSync_q;
    logic [7:0]        nx_q, nx_d;
    logic [7:0]        nxCnt_q, nxCnt_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [21:0]       sa_q, sa_d;
    logic [4:0]        len_q;
    logic              rq_q, rq_d;
    logic              rqUrgent_q, rqUrgent_d;
    logic              pending_q, pending_d;
    logic              reserved_q, reserved_d;
    logic              we_q;
    logic [PAGE_AW-1:0] wa_q, wa_d;
    logic [PW-1:0]     wrPage_q, wrPage_d;
    logic [PW-1:0]     rdPage_q, rdPage_d;
    logic [FW-1:0]     fullCnt_q, fullCnt_d;
    logic              err_q, err_d;
    logic              frameDone_q, frameDone_d;
    logic [15:0]       obdat_q;

    logic              colOrder;
    logic              frameWrap;
    logic              room;
    logic              writeEn;
    logic              commit;
    logic              releasePage;
    logic [11:0]       row12;
    logic [PW+PAGE_AW-1:0] wrAddr;
    logic [PW+PAGE_AW-1:0] rdAddr;

    logic [31:0] mem [DEPTH];

`ifdef CHANNEL_RD_PAGED_COLUMN_ORDER_EN
    assign colOrder = fill_order;
`else
    logic unusedFillOrder;
    assign unusedFillOrder = fill_order;
    assign colOrder = 1'b0;
`endif

    // Row field of the {row, bank} counter, fitted to the 12-bit SDRAM row.
    assign row12 = 12'(y_q >> 2);

    // A reserved page is required for any write; writes stop while init is
    // clearing the pointers so a restarted channel never sees a stale word.
    assign writeEn     = we_q & reserved_q & ~init;
    assign commit      = we_q & ~predrun & reserved_q;
    assign releasePage = next_page & (fullCnt_q != '0);
    assign room        = (int'(fullCnt_q) + int'(reserved_q)) < NPAGES;

    assign wrAddr = {wrPage_q, wa_q};
    assign rdAddr = {rdPage_q, ra[PAGE_AW:1]};

    // Tile address walk. Row order steps nx first and {row, bank} on nx wrap;
    // column order swaps the roles. frameWrap marks the start that closes the
    // frame (both counters wrapping together).
    always_comb begin
        nx_d      = nx_q;
        nxCnt_d   = nxCnt_q;
        y_d       = y_q;
        frameWrap = 1'b0;
        if (start) begin
            if (colOrder) begin
                if (y_q == y_max) begin
                    y_d = '0;
                    if (nxCnt_q == nx_max) begin
                        nx_d      = '0;
                        nxCnt_d   = '0;
                        frameWrap = 1'b1;
                    end else begin
                        nx_d    = nx_q + x_shift;
                        nxCnt_d = nxCnt_q + 8'd1;
                    end
                end else begin
                    y_d = y_q + Y_W'(1);
                end
            end else begin
                if (nxCnt_q == nx_max) begin
                    nx_d    = '0;
                    nxCnt_d = '0;
                    if (y_q == y_max) begin
                        y_d       = '0;
                        frameWrap = 1'b1;
                    end else begin
                        y_d = y_q + Y_W'(1);
                    end
                end else begin
                    nx_d    = nx_q + x_shift;
                    nxCnt_d = nxCnt_q + 8'd1;
                end
            end
        end
        if (init) begin
            nx_d      = '0;
            nxCnt_d   = '0;
            y_d       = '0;
            frameWrap = 1'b0;
        end
    end

    // Request handshake, page reservation and the page ring pointers. A
    // commit and a release on the same edge cancel in fullCnt while both
    // pointers still advance.
    always_comb begin
        sa_d        = sa_q;
        rq_d        = rq_q;
        pending_d   = pending_q;
        reserved_d  = reserved_q;
        wa_d        = wa_q;
        wrPage_d    = wrPage_q;
        rdPage_d    = rdPage_q;
        fullCnt_d   = fullCnt_q;
        err_d       = err_q | (we_q & ~reserved_q);
        frameDone_d = frameWrap;

        if (start) begin
            sa_d       = {fsa + row12, nx_q, y_q[1:0]};
            pending_d  = 1'b1;
            reserved_d = 1'b1;
        end
        if (writeEn) begin
            wa_d = wa_q + PAGE_AW'(1);
        end
        if (commit) begin
            wa_d       = '0;
            wrPage_d   = wrPage_q + PW'(1);
            pending_d  = 1'b0;
            reserved_d = 1'b0;
        end
        if (releasePage) begin
            rdPage_d = rdPage_q + PW'(1);
        end
        case ({commit, releasePage})
            2'b10:   fullCnt_d = fullCnt_q + FW'(1);
            2'b01:   fullCnt_d = fullCnt_q - FW'(1);
            default: fullCnt_d = fullCnt_q;
        endcase

        if (start) begin
            rq_d = 1'b0;
        end else if (runSync_q && enrq && !pending_q && room) begin
            rq_d = 1'b1;
        end

        if (init) begin
            sa_d        = {fsa, 10'b0};
            rq_d        = 1'b0;
            pending_d   = 1'b0;
            reserved_d  = 1'b0;
            wa_d        = '0;
            wrPage_d    = '0;
            rdPage_d    = '0;
            fullCnt_d   = '0;
            err_d       = 1'b0;
            frameDone_d = 1'b0;
        end

        rqUrgent_d = rq_d & (fullCnt_d == '0);
    end

    // Channel state. runSync_q holds requests off until the first falling
    // edge after reset release.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runSync_q   <= 1'b0;
            nx_q        <= '0;
            nxCnt_q     <= '0;
            y_q         <= '0;
            sa_q        <= '0;
            len_q       <= '0;
            rq_q        <= 1'b0;
            rqUrgent_q  <= 1'b0;
            pending_q   <= 1'b0;
            reserved_q  <= 1'b0;
            we_q        <= 1'b0;
            wa_q        <= '0;
            wrPage_q    <= '0;
            rdPage_q    <= '0;
            fullCnt_q   <= '0;
            err_q       <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            runSync_q   <= 1'b1;
            nx_q        <= nx_d;
            nxCnt_q     <= nxCnt_d;
            y_q         <= y_d;
            sa_q        <= sa_d;
            len_q       <= x_max;
            rq_q        <= rq_d;
            rqUrgent_q  <= rqUrgent_d;
            pending_q   <= pending_d;
            reserved_q  <= reserved_d;
            we_q        <= predrun;
            wa_q        <= wa_d;
            wrPage_q    <= wrPage_d;
            rdPage_q    <= rdPage_d;
            fullCnt_q   <= fullCnt_d;
            err_q       <= err_d;
            frameDone_q <= frameDone_d;
        end
    end

    // Buffer write port: one 32-bit SDRAM word per we cycle.
    always_ff @(negedge clk) begin
        if (writeEn) begin
            mem[wrAddr] <= sddi;
        end
    end

    // Buffer read port: 16-bit view, low half at the even address.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obdat_q <= '0;
        end else begin
            obdat_q <= ra[0] ? mem[rdAddr][31:16] : mem[rdAddr][15:0];
        end
    end

    assign rq         = rq_q;
    assign rq_urgent  = rqUrgent_q;
    assign sa         = sa_q;
    assign len        = len_q;
    assign page_rdy   = (fullCnt_q != '0);
    assign page_num   = rdPage_q;
    assign obdat      = obdat_q;
    assign frame_done = frameDone_q;
    assign err        = err_q;

endmodule

// File: tb/tb_channel_rd_paged.sv
// tb_channel_rd_paged
// -------------------
// Self-checking bench for channel_rd_paged. Expected tile addresses come from
// the closed-form position of each start within the frame; expected buffer
// contents come from a FIFO-of-pages model filled as bursts are delivered.
module tb_channel_rd_paged;

    localparam int NPAGES  = 4;
    localparam int PAGE_AW = 8;
    localparam int Y_W     = 14;

    logic              clk;
    logic              rst_n;
    logic              init;
    logic              enrq;
    logic [11:0]       fsa;
    logic [4:0]        x_max;
    logic [7:0]        x_shift;
    logic [7:0]        nx_max;
    logic [Y_W-1:0]    y_max;
    logic              fill_order;
    logic              start;
    logic              rq;
    logic              rq_urgent;
    logic [21:0]       sa;
    logic [4:0]        len;
    logic              predrun;
    logic [31:0]       sddi;
    logic              page_rdy;
    logic [1:0]        page_num;
    logic [PAGE_AW:0]  ra;
    logic [15:0]       obdat;
    logic              next_page;
    logic              frame_done;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] modelPage [NPAGES][256];
    int          modelWr;
    int          modelRd;
    int          modelFull;
    logic [31:0] burstData [16];

    channel_rd_paged #(
        .NPAGES (NPAGES),
        .PAGE_AW(PAGE_AW),
        .Y_W    (Y_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .enrq      (enrq),
        .fsa       (fsa),
        .x_max     (x_max),
        .x_shift   (x_shift),
        .nx_max    (nx_max),
        .y_max     (y_max),
        .fill_order(fill_order),
        .start     (start),
        .rq        (rq),
        .rq_urgent (rq_urgent),
        .sa        (sa),
        .len       (len),
        .predrun   (predrun),
        .sddi      (sddi),
        .page_rdy  (page_rdy),
        .page_num  (page_num),
        .ra        (ra),
        .obdat     (obdat),
        .next_page (next_page),
        .frame_done(frame_done),
        .err       (err)
    );

    // Free-running clock; the design works on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hang guard.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One design cycle; inputs change and outputs are sampled on the rising edge.
    task automatic step();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic doInit();
        init = 1'b1;
        step();
        init = 1'b0;
        modelWr   = 0;
        modelRd   = 0;
        modelFull = 0;
    endtask

    task automatic waitRq(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rq === 1'b1) got = 1'b1;
            else step();
        end
    endtask

    task automatic readWord(input int a, output logic [15:0] obs);
        ra = 9'(a);
        step();
        obs = obdat;
    endtask

    // Grant the pending request and deliver n words from burstData. With
    // relAtCommit the consumer releases a page on the commit edge.
    task automatic grantAndBurst(input int n, input bit relAtCommit, output bit got);
        int slot;
        waitRq(got);
        if (got) begin
            start = 1'b1;
            step();
            start   = 1'b0;
            predrun = 1'b1;
            step();
            for (int i = 0; i < n; i++) begin
                sddi    = burstData[i];
                predrun = (i < n - 1);
                if (i == n - 1) next_page = relAtCommit;
                step();
            end
            predrun   = 1'b0;
            next_page = 1'b0;
            sddi      = '0;
            slot = modelWr % NPAGES;
            for (int i = 0; i < n; i++) modelPage[slot][i] = burstData[i];
            modelWr++;
            if (relAtCommit && modelFull > 0) modelRd++;
            else modelFull++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init = 1'b0; enrq = 1'b1; fsa = 12'h100; x_max = 5'd7;
        x_shift = 8'd0; nx_max = 8'd0; y_max = '0; fill_order = 1'b0;
        start = 1'b0; predrun = 1'b0; sddi = '0; ra = '0; next_page = 1'b0;
        step();
        step();
        vectors++; if (rq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rq: got %b expected 0", rq); end
        vectors++; if (rq_urgent !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rq_urgent: got %b expected 0", rq_urgent); end
        vectors++; if (sa !== 22'h0) begin miscompares++; $display("[TB] FAIL reset_sa: got %h expected 0", sa); end
        vectors++; if (len !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_len: got %h expected 0", len); end
        vectors++; if (page_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_page_rdy: got %b expected 0", page_rdy); end
        vectors++; if (page_num !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_page_num: got %h expected 0", page_num); end
        vectors++; if (obdat !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_obdat: got %h expected 0", obdat); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        rst_n = 1'b1;
        step();
        vectors++; if (rq !== 1'b0) begin miscompares++; $display("[TB] FAIL rq_1st_negedge: got %b expected 0", rq); end
        vectors++; if (len !== 5'd7) begin miscompares++; $display("[TB] FAIL len_follow: got %h expected 7", len); end
        step();
        vectors++; if (rq !== 1'b1) begin miscompares++; $display("[TB] FAIL rq_2nd_negedge: got %b expected 1", rq); end
        vectors++; if (rq_urgent !== 1'b1) begin miscompares++; $display("[TB] FAIL rq_urgent_empty: got %b expected 1", rq_urgent); end
        vectors++; if (sa !== 22'h0) begin miscompares++; $display("[TB] FAIL sa_after_release: got %h expected 0", sa); end
        vectors++; if (page_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL page_rdy_after_release: got %b expected 0", page_rdy); end
        doInit();
        vectors++; if (sa !== 22'h040000) begin miscompares++; $display("[TB] FAIL sa_after_init: got %h expected 040000", sa); end
        vectors++; if (rq !== 1'b0) begin miscompares++; $display("[TB] FAIL rq_after_init: got %b expected 0", rq); end
    endtask

    // Config 0 is the documented 3x2 frame; the rest are random geometries.
    task automatic test_address();
        int nxm, ym, xs, fs, per, total, k, yy;
        logic [21:0] expSa;
        logic expFd;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                nxm = 2; ym = 1; xs = 8;
            end else begin
                nxm = $urandom_range(0, 3); ym = $urandom_range(0, 9); xs = $urandom_range(0, 255);
            end
            fs = $urandom_range(0, 4095);
            nx_max = 8'(nxm); y_max = Y_W'(ym); x_shift = 8'(xs); fsa = 12'(fs);
            doInit();
            per   = nxm + 1;
            total = per * (ym + 1) + 2;
            for (int n = 0; n < total; n++) begin
                k  = n % per;
                yy = (n / per) % (ym + 1);
                expSa = {12'((fs + (yy / 4)) % 4096), 8'((k * xs) % 256), 2'(yy % 4)};
                expFd = (((n + 1) % (per * (ym + 1))) == 0);
                start = 1'b1;
                step();
                start = 1'b0;
                vectors++; if (sa !== expSa) begin miscompares++; $display("[TB] FAIL sa_cfg%0d_start%0d: got %h expected %h", c, n, sa, expSa); end
                vectors++; if (frame_done !== expFd) begin miscompares++; $display("[TB] FAIL frame_done_cfg%0d_start%0d: got %b expected %b", c, n, frame_done, expFd); end
                step();
                vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL frame_done_pulse_cfg%0d_start%0d: got %b expected 0", c, n, frame_done); end
            end
        end
        doInit();
    endtask

    task automatic test_fill();
        bit got;
        int a;
        logic [15:0] obs, expH;
        logic [31:0] w;
        doInit();
        for (int g = 0; g < 5; g++) begin
            waitRq(got);
            vectors++; if (got !== (g < 4)) begin miscompares++; $display("[TB] FAIL fill_rq_grant%0d: got %b expected %b", g, got, (g < 4)); end
            if (got) begin
                vectors++; if (rq_urgent !== (g == 0)) begin miscompares++; $display("[TB] FAIL fill_rq_urgent%0d: got %b expected %b", g, rq_urgent, (g == 0)); end
                for (int i = 0; i < 8; i++) burstData[i] = $urandom;
                grantAndBurst(8, 1'b0, got);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++; if (rq !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_rq_full: got %b expected 0", rq); end
        end
        vectors++; if (rq_urgent !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_rq_urgent_full: got %b expected 0", rq_urgent); end
        for (int p = 0; p < 4; p++) begin
            vectors++; if (page_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_page_rdy%0d: got %b expected 1", p, page_rdy); end
            vectors++; if (page_num !== 2'(modelRd % NPAGES)) begin miscompares++; $display("[TB] FAIL fill_page_num%0d: got %0d expected %0d", p, page_num, modelRd % NPAGES); end
            for (int r = 0; r < 3; r++) begin
                a = $urandom_range(0, 15);
                readWord(a, obs);
                w = modelPage[modelRd % NPAGES][a / 2];
                expH = (a % 2 == 1) ? w[31:16] : w[15:0];
                vectors++; if (obs !== expH) begin miscompares++; $display("[TB] FAIL fill_data_p%0d_ra%0d: got %h expected %h", p, a, obs, expH); end
            end
            next_page = 1'b1;
            step();
            next_page = 1'b0;
            modelRd++; modelFull--;
        end
        vectors++; if (page_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_drained: got %b expected 0", page_rdy); end
        next_page = 1'b1;
        step();
        next_page = 1'b0;
        vectors++; if (page_num !== 2'(modelRd % NPAGES)) begin miscompares++; $display("[TB] FAIL empty_next_page_num: got %0d expected %0d", page_num, modelRd % NPAGES); end
        vectors++; if (page_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_next_page_rdy: got %b expected 0", page_rdy); end
    endtask

    task automatic test_readback();
        bit got;
        logic [15:0] obs;
        logic [15:0] expTab [4];
        expTab[0] = 16'h2222; expTab[1] = 16'h1111; expTab[2] = 16'h4444; expTab[3] = 16'h3333;
        doInit();
        burstData[0] = 32'h11112222;
        burstData[1] = 32'h33334444;
        grantAndBurst(2, 1'b0, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL readback_rq: got %b expected 1", got); end
        for (int a = 0; a < 4; a++) begin
            readWord(a, obs);
            vectors++; if (obs !== expTab[a]) begin miscompares++; $display("[TB] FAIL readback_ra%0d: got %h expected %h", a, obs, expTab[a]); end
        end
        next_page = 1'b1;
        step();
        next_page = 1'b0;
    endtask

    task automatic test_coincident();
        bit got;
        int cnt, expCnt, a;
        logic [15:0] obs, expH;
        logic [31:0] w;
        doInit();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) burstData[i] = $urandom;
            grantAndBurst(4, (b == 2), got);
            vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL coincident_rq%0d: got %b expected 1", b, got); end
        end
        vectors++; if (page_num !== 2'd1) begin miscompares++; $display("[TB] FAIL coincident_page_num: got %0d expected 1", page_num); end
        expCnt = modelFull;
        cnt = 0;
        for (int p = 0; p < 8 && page_rdy === 1'b1; p++) begin
            vectors++; if (page_num !== 2'(modelRd % NPAGES)) begin miscompares++; $display("[TB] FAIL coincident_drain_num%0d: got %0d expected %0d", p, page_num, modelRd % NPAGES); end
            for (int r = 0; r < 2; r++) begin
                a = $urandom_range(0, 7);
                readWord(a, obs);
                w = modelPage[modelRd % NPAGES][a / 2];
                expH = (a % 2 == 1) ? w[31:16] : w[15:0];
                vectors++; if (obs !== expH) begin miscompares++; $display("[TB] FAIL coincident_data_p%0d_ra%0d: got %h expected %h", p, a, obs, expH); end
            end
            next_page = 1'b1;
            step();
            next_page = 1'b0;
            modelRd++; modelFull--; cnt++;
        end
        vectors++; if (cnt !== expCnt) begin miscompares++; $display("[TB] FAIL coincident_full_cnt: got %0d expected %0d", cnt, expCnt); end
    endtask

    task automatic test_init_midburst();
        bit got;
        logic [15:0] obs, expH;
        logic [31:0] w;
        doInit();
        waitRq(got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL midburst_rq: got %b expected 1", got); end
        start = 1'b1; step(); start = 1'b0;
        predrun = 1'b1; step();
        sddi = $urandom; step();
        sddi = $urandom; init = 1'b1; step();
        init = 1'b0; sddi = $urandom; step();
        sddi = $urandom; predrun = 1'b0; step();
        sddi = '0; step();
        modelWr = 0; modelRd = 0; modelFull = 0;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL midburst_err: got %b expected 1", err); end
        vectors++; if (page_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL midburst_page_rdy: got %b expected 0", page_rdy); end
        for (int i = 0; i < 5; i++) burstData[i] = $urandom;
        grantAndBurst(5, 1'b0, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL midburst_regrant: got %b expected 1", got); end
        vectors++; if (page_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL midburst_commit: got %b expected 1", page_rdy); end
        vectors++; if (page_num !== 2'd0) begin miscompares++; $display("[TB] FAIL midburst_page_num: got %0d expected 0", page_num); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL midburst_err_sticky: got %b expected 1", err); end
        for (int a = 0; a < 10; a++) begin
            readWord(a, obs);
            w = modelPage[0][a / 2];
            expH = (a % 2 == 1) ? w[31:16] : w[15:0];
            vectors++; if (obs !== expH) begin miscompares++; $display("[TB] FAIL midburst_data_ra%0d: got %h expected %h", a, obs, expH); end
        end
        doInit();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL init_clears_err: got %b expected 0", err); end
    endtask

    task automatic test_back_to_back();
        bit got;
        bit rel;
        int n, a, drains;
        int lenOf [NPAGES];
        logic [15:0] obs, expH;
        logic [31:0] w;
        doInit();
        for (int it = 0; it < 12; it++) begin
            drains = (modelFull == NPAGES) ? 1 : $urandom_range(0, 1);
            for (int d = 0; d < drains && modelFull > 0; d++) begin
                vectors++; if (page_num !== 2'(modelRd % NPAGES)) begin miscompares++; $display("[TB] FAIL b2b_page_num_it%0d: got %0d expected %0d", it, page_num, modelRd % NPAGES); end
                a = $urandom_range(0, 2 * lenOf[modelRd % NPAGES] - 1);
                readWord(a, obs);
                w = modelPage[modelRd % NPAGES][a / 2];
                expH = (a % 2 == 1) ? w[31:16] : w[15:0];
                vectors++; if (obs !== expH) begin miscompares++; $display("[TB] FAIL b2b_data_it%0d_ra%0d: got %h expected %h", it, a, obs, expH); end
                next_page = 1'b1; step(); next_page = 1'b0;
                modelRd++; modelFull--;
            end
            n = $urandom_range(1, 16);
            rel = ($urandom_range(0, 1) == 1) && (modelFull > 0);
            for (int i = 0; i < n; i++) burstData[i] = $urandom;
            lenOf[modelWr % NPAGES] = n;
            grantAndBurst(n, rel, got);
            vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_rq_it%0d: got %b expected 1", it, got); end
            vectors++; if (page_rdy !== (modelFull > 0)) begin miscompares++; $display("[TB] FAIL b2b_page_rdy_it%0d: got %b expected %b", it, page_rdy, (modelFull > 0)); end
        end
        while (modelFull > 0) begin
            a = $urandom_range(0, 2 * lenOf[modelRd % NPAGES] - 1);
            readWord(a, obs);
            w = modelPage[modelRd % NPAGES][a / 2];
            expH = (a % 2 == 1) ? w[31:16] : w[15:0];
            vectors++; if (obs !== expH) begin miscompares++; $display("[TB] FAIL b2b_final_ra%0d: got %h expected %h", a, obs, expH); end
            next_page = 1'b1; step(); next_page = 1'b0;
            modelRd++; modelFull--;
        end
        vectors++; if (page_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drained: got %b expected 0", page_rdy); end
    endtask

`ifdef CHANNEL_RD_PAGED_COLUMN_ORDER_EN
    task automatic test_column_order();
        int xs, k, yy;
        logic [21:0] expSa;
        logic expFd;
        xs = $urandom_range(1, 255);
        fill_order = 1'b1; nx_max = 8'd1; y_max = Y_W'(2); x_shift = 8'(xs); fsa = 12'h0A5;
        doInit();
        for (int n = 0; n < 8; n++) begin
            yy = n % 3;
            k  = (n / 3) % 2;
            expSa = {12'h0A5, 8'((k * xs) % 256), 2'(yy)};
            expFd = (((n + 1) % 6) == 0);
            start = 1'b1; step(); start = 1'b0;
            vectors++; if (sa !== expSa) begin miscompares++; $display("[TB] FAIL col_sa_start%0d: got %h expected %h", n, sa, expSa); end
            vectors++; if (frame_done !== expFd) begin miscompares++; $display("[TB] FAIL col_frame_done_start%0d: got %b expected %b", n, frame_done, expFd); end
            step();
        end
        fill_order = 1'b0;
        doInit();
    endtask
`endif

    initial begin
        test_reset();
        test_address();
        test_fill();
        test_readback();
        test_coincident();
        test_init_midburst();
        test_back_to_back();
`ifdef CHANNEL_RD_PAGED_COLUMN_ORDER_EN
        test_column_order();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
